wt_dcache_rd_arb: RTL

- Parametrised read-port arbiter in front of the write-through dcache tag/data arrays. It replaces the fixed 3-port static-priority selection with N ports.
- Two priority classes; round-robin within each class.
- Age-based promotion of starved low-priority ports.
- One-cycle registered response tag that steers the readout mux.
- Sits between the load/PTW controllers plus write buffer and the cache memory.

---
 rtl/wt_cache_pkg.sv | 22 ++
 rtl/wt_dcache_rr_pick.sv | 38 +++
 rtl/wt_dcache_rd_arb.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/wt_cache_pkg.sv
// Shared widths, request payload type and arbitration class for the
// write-through dcache read path.
package wt_cache_pkg;

    localparam int DCACHE_TAG_WIDTH       = 20;
    localparam int DCACHE_CL_IDX_WIDTH    = 8;
    localparam int DCACHE_OFFSET_WIDTH    = 4;
    localparam int DCACHE_RD_STARVE_LIMIT = 15;

    typedef struct packed {
        logic                           tag_only;
        logic [DCACHE_TAG_WIDTH-1:0]    tag;
        logic [DCACHE_CL_IDX_WIDTH-1:0] idx;
        logic [DCACHE_OFFSET_WIDTH-1:0] off;
    } dcache_rd_req_t;

    typedef enum logic {
        RD_CLASS_LO = 1'b0,
        RD_CLASS_HI = 1'b1
    } rd_class_e;

endpackage

// File: rtl/wt_dcache_rr_pick.sv
// One-hot round-robin picker: grants the first set request at or after ptr,
// wrapping modulo N.
module wt_dcache_rr_pick #(
    parameter  int N  = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          vld
);

    logic [PW:0]   pos;
    logic [PW-1:0] cand;

    // The extra bit in pos holds ptr+i before folding it back below N.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        vld  = 1'b0;
        pos  = '0;
        cand = '0;
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, ptr} + (PW+1)'(i);
            if (pos >= (PW+1)'(N)) begin
                pos = pos - (PW+1)'(N);
            end
            cand = pos[PW-1:0];
            if (!vld && req[cand]) begin
                vld       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/wt_dcache_rd_arb.sv
// N-port read arbiter in front of the dcache arrays: two priority classes,
// round-robin inside each class, age promotion of starved low ports.
module wt_dcache_rd_arb
    import wt_cache_pkg::*;
#(
    parameter  int NumPorts     = 3,
    parameter  int TagWidth     = DCACHE_TAG_WIDTH,
    parameter  int IdxWidth     = DCACHE_CL_IDX_WIDTH,
    parameter  int OffWidth     = DCACHE_OFFSET_WIDTH,
    parameter  int StarveLimit  = DCACHE_RD_STARVE_LIMIT,
    localparam int PortIdxWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1,
    localparam int CntWidth     = (StarveLimit > 0) ? $clog2(StarveLimit + 1) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         block_i,
    input  logic [NumPorts-1:0]          rd_req_i,
    input  logic [NumPorts-1:0]          rd_prio_i,
    input  logic [NumPorts-1:0]          rd_tag_only_i,
    input  logic [NumPorts*TagWidth-1:0] rd_tag_i,
    input  logic [NumPorts*IdxWidth-1:0] rd_idx_i,
    input  logic [NumPorts*OffWidth-1:0] rd_off_i,
    output logic [NumPorts-1:0]          rd_ack_o,
    output logic                         mem_req_o,
    output logic                         mem_tag_only_o,
    output logic [TagWidth-1:0]          mem_tag_o,
    output logic [IdxWidth-1:0]          mem_idx_o,
    output logic [OffWidth-1:0]          mem_off_o,
    output logic                         rsp_vld_o,
    output logic [PortIdxWidth-1:0]      rsp_port_o,
    output logic                         rsp_tag_only_o,
    output logic                         starve_promote_o
);

    // Same layout as dcache_rd_req_t, but sized by this instance's parameters.
    typedef struct packed {
        logic                tag_only;
        logic [TagWidth-1:0] tag;
        logic [IdxWidth-1:0] idx;
        logic [OffWidth-1:0] off;
    } rd_req_t;

    rd_req_t                 port_req [NumPorts];
    rd_req_t                 win_req;
    logic [NumPorts-1:0]     eligible, eff_hi, hi_gnt, lo_gnt;
    logic [PortIdxWidth-1:0] hi_ptr, lo_ptr, hi_idx, lo_idx, winner;
    logic                    hi_vld, lo_vld, grant;
    logic [CntWidth-1:0]     starve_cnt [NumPorts];
    rd_class_e               win_class;

    function automatic logic [PortIdxWidth-1:0] wrap_inc(input logic [PortIdxWidth-1:0] p);
        return (p == PortIdxWidth'(NumPorts - 1)) ? '0 : p + PortIdxWidth'(1);
    endfunction

    // A low port that has waited StarveLimit cycles competes as high class.
    always_comb begin
        port_req = '{default: '0};
        eff_hi   = '0;
        for (int k = 0; k < NumPorts; k++) begin
            port_req[k].tag_only = rd_tag_only_i[k];
            port_req[k].tag      = rd_tag_i[k*TagWidth +: TagWidth];
            port_req[k].idx      = rd_idx_i[k*IdxWidth +: IdxWidth];
            port_req[k].off      = rd_off_i[k*OffWidth +: OffWidth];
            eff_hi[k] = rd_prio_i[k] |
                        ((StarveLimit != 0) && (starve_cnt[k] == CntWidth'(StarveLimit)));
        end
    end

    assign eligible = rd_req_i & {NumPorts{rst_ni & ~block_i}};

    wt_dcache_rr_pick #(.N(NumPorts)) u_pick_hi (
        .req (eligible & eff_hi),
        .ptr (hi_ptr),
        .gnt (hi_gnt),
        .idx (hi_idx),
        .vld (hi_vld)
    );

    wt_dcache_rr_pick #(.N(NumPorts)) u_pick_lo (
        .req (eligible & ~eff_hi),
        .ptr (lo_ptr),
        .gnt (lo_gnt),
        .idx (lo_idx),
        .vld (lo_vld)
    );

    assign grant = hi_vld | lo_vld;

    always_comb begin
        win_class        = hi_vld ? RD_CLASS_HI : RD_CLASS_LO;
        rd_ack_o         = hi_vld ? hi_gnt : lo_gnt;
        winner           = hi_vld ? hi_idx : lo_idx;
        win_req          = grant ? port_req[winner] : '0;
        mem_req_o        = grant;
        mem_tag_only_o   = win_req.tag_only;
        mem_tag_o        = win_req.tag;
        mem_idx_o        = win_req.idx;
        mem_off_o        = win_req.off;
        starve_promote_o = grant && !rd_prio_i[winner] && eff_hi[winner];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hi_ptr <= '0;
            lo_ptr <= '0;
        end else if (grant) begin
            if (win_class == RD_CLASS_HI) begin
                hi_ptr <= wrap_inc(winner);
            end else begin
                lo_ptr <= wrap_inc(winner);
            end
        end
    end

    // Ageing keeps running while the memory is blocked.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NumPorts; k++) begin
            if (!rst_ni) begin
                starve_cnt[k] <= '0;
            end else if (rd_req_i[k] && !rd_prio_i[k] && !rd_ack_o[k]) begin
                if (starve_cnt[k] != CntWidth'(StarveLimit)) begin
                    starve_cnt[k] <= starve_cnt[k] + CntWidth'(1);
                end
            end else begin
                starve_cnt[k] <= '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rsp_vld_o      <= 1'b0;
            rsp_port_o     <= '0;
            rsp_tag_only_o <= 1'b0;
        end else begin
            rsp_vld_o <= grant;
            if (grant) begin
                rsp_port_o     <= winner;
                rsp_tag_only_o <= win_req.tag_only;
            end
        end
    end

endmodule
